cdb_broadcaster: RTL and testbench

- Transmit end of the common data bus (CDB).
- Collects completed results from the functional units.
- Arbitrates them onto WAYS parallel CDB lanes; each lane carries valid/tag/data/ROB number.
- Reservation-station entries snoop these lanes to wake up operands; the ROB snoops them to mark completion.
- Each FU has a one-entry holding register with a valid/ready handshake, so an FU stalls only when its result cannot be broadcast.

---
 rtl/cdb_broadcaster_pkg.sv | 24 ++
 rtl/cdb_broadcaster_if.sv | 29 ++
 rtl/cdb_broadcaster_rr_multi_grant_arbiter.sv | 44 ++++
 rtl/cdb_broadcaster.sv | 81 ++++++++
 tb/tb_cdb_broadcaster.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_broadcaster_pkg.sv
// rtl/cdb_broadcaster_pkg.sv - shared CDB lane type and widths
package cdb_broadcaster_pkg;

  localparam int TAG_BITS  = 5;
  localparam int ROB_BITS  = 5;
  localparam int DATA_BITS = 64;

  typedef logic [TAG_BITS-1:0]  tag_t;
  typedef logic [ROB_BITS-1:0]  rob_t;
  typedef logic [DATA_BITS-1:0] data_t;

  // One broadcast slot as seen by reservation-station and ROB snoopers.
  typedef struct packed {
    logic  valid;
    tag_t  tag;
    data_t data;
    rob_t  rob;
  } cdb_lane_t;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_broadcaster_if.sv
// rtl/cdb_broadcaster_if.sv - FU result ports and CDB lanes
interface cdb_broadcaster_if #(
  parameter int N_FU = 4,
  parameter int WAYS = 2
);

  logic [N_FU-1:0]                                fu_valid;
  logic [N_FU*cdb_broadcaster_pkg::TAG_BITS-1:0]  fu_tag;
  logic [N_FU*cdb_broadcaster_pkg::DATA_BITS-1:0] fu_data;
  logic [N_FU*cdb_broadcaster_pkg::ROB_BITS-1:0]  fu_rob;
  logic [N_FU-1:0]                                fu_ready;

  logic [WAYS-1:0]                                cdb_valid;
  logic [WAYS*cdb_broadcaster_pkg::TAG_BITS-1:0]  cdb_tag;
  logic [WAYS*cdb_broadcaster_pkg::DATA_BITS-1:0] cdb_data;
  logic [WAYS*cdb_broadcaster_pkg::ROB_BITS-1:0]  cdb_rob;

  // master is the functional-unit side, slave is the broadcaster.
  modport master (
    output fu_valid, fu_tag, fu_data, fu_rob,
    input  fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_rob
  );

  modport slave (
    input  fu_valid, fu_tag, fu_data, fu_rob,
    output fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_rob
  );

endinterface

// File: rtl/cdb_broadcaster_rr_multi_grant_arbiter.sv
// rtl/cdb_broadcaster_rr_multi_grant_arbiter.sv - up to WAYS grants in rotating order
module rr_multi_grant_arbiter #(
  parameter int N_FU  = 4,
  parameter int WAYS  = 2,
  parameter int PTR_W = 2
) (
  input  logic [N_FU-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_FU-1:0]  grant,
  output logic [WAYS-1:0]  lane_vld,
  output logic [PTR_W-1:0] lane_idx [WAYS],
  output logic [PTR_W-1:0] next_ptr,
  output logic             any_grant
);

  always_comb begin
    logic [PTR_W-1:0] idx;
    int               cnt;
    grant    = '0;
    lane_vld = '0;
    next_ptr = rr_ptr;
    idx      = '0;
    cnt      = 0;
    for (int w = 0; w < WAYS; w++) lane_idx[w] = '0;
    // The k-th hit lands on lane k, so lanes are packed from lane 0.
    for (int k = 0; k < N_FU; k++) begin
      idx = PTR_W'((int'(rr_ptr) + k) % N_FU);
      if (req[idx] && cnt < WAYS) begin
        grant[idx] = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
          if (cnt == w) begin
            lane_vld[w] = 1'b1;
            lane_idx[w] = idx;
          end
        end
        next_ptr = PTR_W'((int'(idx) + 1) % N_FU);
        cnt      = cnt + 1;
      end
    end
  end

  assign any_grant = |grant;

endmodule

// File: rtl/cdb_broadcaster.sv
// rtl/cdb_broadcaster.sv - FU result holding registers arbitrated onto WAYS CDB lanes
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int N_FU = 4,
  parameter int WAYS = 2
) (
  input logic              clock,
  input logic              reset,
  input logic              flush,
  cdb_broadcaster_if.slave bus
);

  localparam int PTR_W = idx_bits(N_FU);

  cdb_lane_t        hold_q [N_FU];
  cdb_lane_t        lane_q [WAYS];
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] next_ptr;
  logic [N_FU-1:0]  hv;
  logic [N_FU-1:0]  grant;
  logic [WAYS-1:0]  lane_vld;
  logic [PTR_W-1:0] lane_idx [WAYS];
  logic             any_grant;

  for (genvar i = 0; i < N_FU; i++) begin : g_hv
    assign hv[i] = hold_q[i].valid;
  end

  rr_multi_grant_arbiter #(
    .N_FU  (N_FU),
    .WAYS  (WAYS),
    .PTR_W (PTR_W)
  ) u_arb (
    .req       (hv),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .lane_vld  (lane_vld),
    .lane_idx  (lane_idx),
    .next_ptr  (next_ptr),
    .any_grant (any_grant)
  );

  // A slot being broadcast this cycle can take a new result in the same edge.
  assign bus.fu_ready = ~hv | grant;

  for (genvar w = 0; w < WAYS; w++) begin : g_lane
    assign bus.cdb_valid[w]                         = lane_q[w].valid;
    assign bus.cdb_tag[w*TAG_BITS +: TAG_BITS]      = lane_q[w].tag;
    assign bus.cdb_data[w*DATA_BITS +: DATA_BITS]   = lane_q[w].data;
    assign bus.cdb_rob[w*ROB_BITS +: ROB_BITS]      = lane_q[w].rob;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_FU; i++) hold_q[i] <= '0;
      for (int w = 0; w < WAYS; w++) lane_q[w] <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      // Squash held and in-flight results; the pointer keeps its position.
      for (int i = 0; i < N_FU; i++) hold_q[i].valid <= 1'b0;
      for (int w = 0; w < WAYS; w++) lane_q[w] <= '0;
    end else begin
      for (int i = 0; i < N_FU; i++) begin
        if (bus.fu_valid[i] && bus.fu_ready[i]) begin
          hold_q[i] <= {1'b1,
                        bus.fu_tag[i*TAG_BITS +: TAG_BITS],
                        bus.fu_data[i*DATA_BITS +: DATA_BITS],
                        bus.fu_rob[i*ROB_BITS +: ROB_BITS]};
        end else if (grant[i]) begin
          hold_q[i].valid <= 1'b0;
        end
      end
      for (int w = 0; w < WAYS; w++) begin
        lane_q[w] <= lane_vld[w] ? hold_q[lane_idx[w]] : '0;
      end
      if (any_grant) rr_ptr <= next_ptr;
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb/tb_cdb_broadcaster.sv - scoreboard bench for cdb_broadcaster
`timescale 1ns/1ps
module tb_cdb_broadcaster;
  import cdb_broadcaster_pkg::*;

  typedef struct {
    int    lane;
    int    cyc;
    tag_t  tag;
    data_t data;
    rob_t  rob;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t q2[$];
  exp_t q1[$];

  cdb_broadcaster_if #(.N_FU(4), .WAYS(2)) bus2();
  cdb_broadcaster_if #(.N_FU(4), .WAYS(1)) bus1();

  cdb_broadcaster #(.N_FU(4), .WAYS(2)) dut2 (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus2.slave)
  );

  cdb_broadcaster #(.N_FU(4), .WAYS(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus1.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic mon(input int d, input int w, input logic v, input tag_t t,
                     input data_t dt, input rob_t r);
    exp_t e;
    int   n;
    n = (d == 2) ? q2.size() : q1.size();
    if (v) begin
      if (n == 0) begin
        total++;
        bad++;
        $display("FAIL dut%0d_unexpected lane=%0d cyc=%0d actual tag=%0h required no broadcast",
                 d, w, cyc, t);
      end else begin
        if (d == 2) e = q2.pop_front();
        else        e = q1.pop_front();
        check($sformatf("dut%0d_bcast{cyc,lane,tag,data,rob}", d),
              {cyc[15:0], w[3:0], t, dt, r},
              {e.cyc[15:0], e.lane[3:0], e.tag, e.data, e.rob});
      end
    end else begin
      check($sformatf("dut%0d_idle_lane%0d_zero", d, w), {t, dt, r}, '0);
    end
  endtask

  always @(negedge clock) begin
    for (int w = 0; w < 2; w++) begin
      mon(2, w, bus2.cdb_valid[w], bus2.cdb_tag[w*TAG_BITS +: TAG_BITS],
          bus2.cdb_data[w*DATA_BITS +: DATA_BITS], bus2.cdb_rob[w*ROB_BITS +: ROB_BITS]);
    end
    mon(1, 0, bus1.cdb_valid[0], bus1.cdb_tag, bus1.cdb_data, bus1.cdb_rob);
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drv2(input int i, input tag_t t, input data_t d, input rob_t r);
    bus2.fu_valid[i]                       = 1'b1;
    bus2.fu_tag[i*TAG_BITS +: TAG_BITS]    = t;
    bus2.fu_data[i*DATA_BITS +: DATA_BITS] = d;
    bus2.fu_rob[i*ROB_BITS +: ROB_BITS]    = r;
  endtask

  task automatic drv1(input int i, input tag_t t, input data_t d, input rob_t r);
    bus1.fu_valid[i]                       = 1'b1;
    bus1.fu_tag[i*TAG_BITS +: TAG_BITS]    = t;
    bus1.fu_data[i*DATA_BITS +: DATA_BITS] = d;
    bus1.fu_rob[i*ROB_BITS +: ROB_BITS]    = r;
  endtask

  task automatic exp2(input int lane, input int cy, input tag_t t, input data_t d, input rob_t r);
    exp_t e;
    e.lane = lane; e.cyc = cy; e.tag = t; e.data = d; e.rob = r;
    q2.push_back(e);
  endtask

  task automatic exp1(input int cy, input tag_t t, input data_t d, input rob_t r);
    exp_t e;
    e.lane = 0; e.cyc = cy; e.tag = t; e.data = d; e.rob = r;
    q1.push_back(e);
  endtask

  initial begin
    int         c;
    int         n0;
    int         n3;
    logic [3:0] rdy;
    tag_t       t;

    bus2.fu_valid = '0; bus2.fu_tag = '0; bus2.fu_data = '0; bus2.fu_rob = '0;
    bus1.fu_valid = '0; bus1.fu_tag = '0; bus1.fu_data = '0; bus1.fu_rob = '0;

    step(2);
    check("reset_cdb_valid2", bus2.cdb_valid, 2'b00);
    check("reset_fu_ready2", bus2.fu_ready, 4'hf);
    check("reset_cdb_valid1", bus1.cdb_valid, 1'b0);
    check("reset_fu_ready1", bus1.fu_ready, 4'hf);
    reset = 1'b0;
    step(1);

    // Reset mid-traffic: four held results never reach the CDB.
    for (int i = 0; i < 4; i++) drv2(i, tag_t'(i + 1), data_t'(64'h50 + i), rob_t'(i));
    step(1);
    bus2.fu_valid = '0;
    check("full_fu_ready", bus2.fu_ready, 4'b0011);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("rst_mid_cdb_valid", bus2.cdb_valid, 2'b00);
    check("rst_mid_fu_ready", bus2.fu_ready, 4'hf);
    step(4);

    // Single result on FU2.
    c = cyc;
    drv2(2, 5'd7, 64'hDEAD, 5'd3);
    exp2(0, c + 2, 5'd7, 64'hDEAD, 5'd3);
    step(1);
    bus2.fu_valid = '0;
    step(3);

    // rr_ptr is now 3: FU3 wins lane 0 over FU0.
    c = cyc;
    drv2(0, 5'd10, 64'hA0, 5'd1);
    drv2(3, 5'd13, 64'hA3, 5'd4);
    exp2(0, c + 2, 5'd13, 64'hA3, 5'd4);
    exp2(1, c + 2, 5'd10, 64'hA0, 5'd1);
    step(1);
    bus2.fu_valid = '0;
    step(3);

    // Reset returns rr_ptr to 0, then oversubscribe.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    c = cyc;
    for (int i = 0; i < 4; i++) drv2(i, tag_t'(16 + i), data_t'(64'h100 + i), rob_t'(8 + i));
    exp2(0, c + 2, 5'd16, 64'h100, 5'd8);
    exp2(1, c + 2, 5'd17, 64'h101, 5'd9);
    exp2(0, c + 3, 5'd18, 64'h102, 5'd10);
    exp2(1, c + 3, 5'd19, 64'h103, 5'd11);
    step(1);
    bus2.fu_valid = '0;
    check("oversub_fu_ready_first", bus2.fu_ready, 4'b0011);
    step(1);
    check("oversub_fu_ready_second", bus2.fu_ready, 4'b1111);
    step(3);

    // Same-slot reload on FU1.
    c = cyc;
    drv2(1, 5'd20, 64'h200, 5'd12);
    exp2(0, c + 2, 5'd20, 64'h200, 5'd12);
    step(1);
    check("reload_fu_ready1", bus2.fu_ready[1], 1'b1);
    drv2(1, 5'd9, 64'h900, 5'd13);
    exp2(0, c + 3, 5'd9, 64'h900, 5'd13);
    step(1);
    bus2.fu_valid = '0;
    step(3);

    // Flush with FU0/FU2 held and FU3 offering.
    drv2(0, 5'd21, 64'h210, 5'd14);
    drv2(2, 5'd22, 64'h220, 5'd15);
    step(1);
    bus2.fu_valid = '0;
    flush = 1'b1;
    drv2(3, 5'd23, 64'h230, 5'd16);
    step(1);
    flush = 1'b0;
    bus2.fu_valid = '0;
    check("flush_cdb_valid", bus2.cdb_valid, 2'b00);
    check("flush_fu_ready", bus2.fu_ready, 4'hf);
    step(3);

    // rr_ptr held at 2 across the flush: FU2 before FU1.
    c = cyc;
    drv2(1, 5'd24, 64'h240, 5'd5);
    drv2(2, 5'd25, 64'h250, 5'd6);
    exp2(0, c + 2, 5'd25, 64'h250, 5'd6);
    exp2(1, c + 2, 5'd24, 64'h240, 5'd5);
    step(1);
    bus2.fu_valid = '0;
    step(3);

    // Fairness on the single-lane instance: FU0 and FU3 alternate.
    c = cyc;
    for (int k = 0; k < 21; k++) begin
      t = (k % 2 == 0) ? tag_t'(k / 2) : tag_t'(16 + (k - 1) / 2);
      exp1(c + 2 + k, t, 64'hF000 + data_t'(t), rob_t'(t));
    end
    n0 = 0;
    n3 = 0;
    for (int m = 0; m < 20; m++) begin
      drv1(0, tag_t'(n0), 64'hF000 + data_t'(n0), rob_t'(n0));
      drv1(3, tag_t'(16 + n3), 64'hF000 + data_t'(16 + n3), rob_t'(16 + n3));
      rdy = bus1.fu_ready;
      step(1);
      if (rdy[0]) n0++;
      if (rdy[3]) n3++;
    end
    bus1.fu_valid = '0;
    step(5);

    check("q2_drained", q2.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
